servio_loader: RTL

- Byte-stream program loader sitting directly upstream of the servio ROM write port (avs_s1).
- Parses framed commands from an Avalon-ST byte source (UART/JTAG bridge) and writes program bytes into the shared instruction ROM.
- Drives a core-hold line so the SERV cores stay stopped while the ROM is rewritten, and releases them on command.

---
 rtl/servio_pkg.sv | 27 ++
 rtl/servio_loader_timer.sv | 34 +++
 rtl/servio_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/servio_pkg.sv
// Shared constants and FSM state encoding for the servio program loader.
package servio_pkg;

  localparam logic [7:0] SYNC      = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_CMD  = 4'd1,
    ST_AH   = 4'd2,
    ST_AL   = 4'd3,
    ST_LH   = 4'd4,
    ST_LL   = 4'd5,
    ST_DATA = 4'd6,
    ST_CHK  = 4'd7,
    ST_EXEC = 4'd8
  } state_e;

  function automatic logic is_known_cmd(input logic [7:0] c);
    return (c == CMD_WRITE) || (c == CMD_RUN) || (c == CMD_HALT);
  endfunction

endpackage

// File: rtl/servio_loader_timer.sv
// Inter-byte timeout counter: cleared by an accepted byte or when disabled,
// expire asserts once TIMEOUT idle cycles have elapsed with no byte.
module servio_loader_timer #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // A byte arriving on the maturing cycle wins over the timeout.
  assign expire = en && !clr && (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servio_loader.sv
// Framed byte-stream ROM loader with core-hold control for servio.
// Optional SERVIO_LOADER_ECHO_EN adds an ACK/NAK response stream.
module servio_loader
  import servio_pkg::*;
#(
  parameter  int DATA_DEPTH = 1024,
  parameter  int TIMEOUT    = 65535,
  localparam int AW         = $clog2(DATA_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    asi_in_data,
  input  logic          asi_in_valid,
  output logic          asi_in_ready,
  output logic [AW-1:0] avm_s1_address,
  output logic          avm_s1_write,
  output logic [7:0]    avm_s1_writedata,
`ifdef SERVIO_LOADER_ECHO_EN
  output logic [7:0]    aso_out_data,
  output logic          aso_out_valid,
  input  logic          aso_out_ready,
`endif
  output logic          coe_hold,
  output logic          coe_busy,
  output logic          coe_err
);

  state_e        state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [15:0]   rem_q, rem_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          lenz_q, lenz_d;
  logic          ok_q, ok_d;
  logic          hold_q, hold_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [7:0]    wd_q, wd_d;

  logic          accept;
  logic          expire;
  logic          exec_go;
  logic [7:0]    sum_nx;
  logic [15:0]   hi_word;

  // Valid/ready: a byte transfers on a rising edge where asi_in_valid and
  // asi_in_ready are both high; ready is registered and low only in EXEC.
  assign accept  = asi_in_valid && ready_q;
  assign sum_nx  = sum_q + asi_in_data;
  assign hi_word = {hi_q, asi_in_data};

  servio_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      ((state_q != ST_IDLE) && (state_q != ST_EXEC)),
    .expire  (expire)
  );

`ifdef SERVIO_LOADER_ECHO_EN
  logic nak_pend_q, nak_pend_d;
  logic abort;

  assign abort = expire ||
                 ((state_q == ST_CMD) && accept && !is_known_cmd(asi_in_data));

  // A pending abort NAK is delivered before any EXEC response.
  assign aso_out_valid = nak_pend_q || (state_q == ST_EXEC);
  assign aso_out_data  = (nak_pend_q || !ok_q) ? NAK : ACK;
  assign exec_go       = aso_out_ready && !nak_pend_q;

  always_comb begin
    nak_pend_d = nak_pend_q;
    if (abort)                            nak_pend_d = 1'b1;
    else if (nak_pend_q && aso_out_ready) nak_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) nak_pend_q <= 1'b0;
    else          nak_pend_q <= nak_pend_d;
  end
`else
  assign exec_go = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    cmd_d   = cmd_q;
    lenz_d  = lenz_q;
    ok_d    = ok_q;
    hold_d  = hold_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    if (expire) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept && asi_in_data == SYNC) state_d = ST_CMD;
        ST_CMD: if (accept) begin
          cmd_d = asi_in_data;
          sum_d = asi_in_data;
          if (is_known_cmd(asi_in_data)) begin
            state_d = ST_AH;
            if (asi_in_data == CMD_WRITE) hold_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_AH: if (accept) begin
          hi_d    = asi_in_data;
          sum_d   = sum_nx;
          state_d = ST_AL;
        end
        ST_AL: if (accept) begin
          ptr_d   = hi_word[AW-1:0];
          sum_d   = sum_nx;
          state_d = ST_LH;
        end
        ST_LH: if (accept) begin
          hi_d    = asi_in_data;
          sum_d   = sum_nx;
          state_d = ST_LL;
        end
        ST_LL: if (accept) begin
          rem_d   = hi_word;
          lenz_d  = (hi_word == 16'd0);
          sum_d   = sum_nx;
          state_d = (hi_word == 16'd0) ? ST_CHK : ST_DATA;
        end
        ST_DATA: if (accept) begin
          wr_d  = (cmd_q == CMD_WRITE);
          wa_d  = ptr_q;
          wd_d  = asi_in_data;
          ptr_d = ptr_q + AW'(1);
          rem_d = rem_q - 16'd1;
          sum_d = sum_nx;
          if (rem_q == 16'd1) state_d = ST_CHK;
        end
        ST_CHK: if (accept) begin
          ok_d    = (sum_nx == 8'h00) && ((cmd_q == CMD_WRITE) || lenz_q);
          state_d = ST_EXEC;
        end
        ST_EXEC: if (exec_go) begin
          state_d = ST_IDLE;
          if (ok_q) begin
            err_d = 1'b0;
            if (cmd_q == CMD_RUN)       hold_d = 1'b0;
            else if (cmd_q == CMD_HALT) hold_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d = (state_d != ST_EXEC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
      cmd_q   <= '0;
      lenz_q  <= 1'b0;
      ok_q    <= 1'b0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      cmd_q   <= cmd_d;
      lenz_q  <= lenz_d;
      ok_q    <= ok_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign asi_in_ready     = ready_q;
  assign avm_s1_write     = wr_q;
  assign avm_s1_address   = wa_q;
  assign avm_s1_writedata = wd_q;
  assign coe_hold         = hold_q;
  assign coe_err          = err_q;
  assign coe_busy         = (state_q != ST_IDLE);

endmodule
